// File: rtl/charge_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : charge_session_ctrl
// Description : Coin-charger session sequencer. Keypad entry of an amount,
//               coin collection, then a timed charging run on a 1 s tick.
// Revision    : 1.0 - initial release
// ============================================================================
module charge_session_ctrl #(
    parameter int unsigned AW           = 8,
    parameter int unsigned TW           = 16,
    parameter int unsigned MAX_AMT      = 20,
    parameter int unsigned SEC_PER_UNIT = 60
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [3:0]    key_data,
    input  logic          key_start,
    input  logic          key_ok,
    input  logic          key_clear,
    input  logic          coin_pulse,
    input  logic          tick,
    output logic [2:0]    state,
    output logic [AW-1:0] amount,
    output logic [AW-1:0] paid,
    output logic [TW-1:0] remain_time,
    output logic          charging,
    output logic          err,
    output logic          refund,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INPUT  = 3'd1,
        ST_PAY    = 3'd2,
        ST_CHARGE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Digit accumulation needs headroom for amount*10+9 before the range check.
    localparam int unsigned       c_MW  = AW + 4;
    localparam logic [c_MW-1:0]   c_MAX = c_MW'(MAX_AMT);
    localparam logic [c_MW-1:0]   c_TEN = c_MW'(10);
    localparam logic [TW-1:0]     c_SPU = TW'(SEC_PER_UNIT);
    localparam logic [AW-1:0]     c_ONE_A = AW'(1);
    localparam logic [TW-1:0]     c_ONE_T = TW'(1);

    state_t        r_state, w_state;
    logic [AW-1:0] r_amount, w_amount;
    logic [AW-1:0] r_paid, w_paid;
    logic [TW-1:0] r_remain, w_remain;
    logic          r_charging, r_err, r_refund, r_done;
    logic          w_err, w_refund;

    logic          w_clr, w_ok, w_start, w_dig;
    logic [c_MW-1:0] w_cand;
    logic [TW-1:0]   w_run_time;

    // Only the highest-priority key of a cycle survives.
    assign w_clr   = key_clear;
    assign w_ok    = key_ok & ~key_clear;
    assign w_start = key_start & ~key_ok & ~key_clear;
    assign w_dig   = key_valid & ~key_start & ~key_ok & ~key_clear & (key_data <= 4'd9);

    assign w_cand     = c_MW'(r_amount) * c_TEN + c_MW'(key_data);
    assign w_run_time = TW'(r_amount) * c_SPU;

    always_comb begin
        w_state  = r_state;
        w_amount = r_amount;
        w_paid   = r_paid;
        w_remain = r_remain;
        w_err    = 1'b0;
        w_refund = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state = ST_INPUT;
            end
            ST_INPUT: begin
                if (w_clr) begin
                    w_state = ST_IDLE;
                end else if (w_ok) begin
                    if (r_amount != '0) w_state = ST_PAY;
                    else                w_err   = 1'b1;
                end else if (w_dig) begin
                    if (w_cand <= c_MAX) w_amount = w_cand[AW-1:0];
                    else                 w_err    = 1'b1;
                end
            end
            ST_PAY: begin
                if (w_clr) begin
                    w_state  = ST_IDLE;
                    w_refund = (r_paid != '0);
                end else if (coin_pulse && (r_paid < r_amount)) begin
                    w_paid = r_paid + c_ONE_A;
                    if (w_paid == r_amount) begin
                        w_state  = ST_CHARGE;
                        w_remain = w_run_time;
                    end
                end
            end
            ST_CHARGE: begin
                if (w_clr) begin
                    w_state = ST_IDLE;
                end else if (tick && (r_remain != '0)) begin
                    w_remain = r_remain - c_ONE_T;
                    if (r_remain == c_ONE_T) w_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
        // Every path into IDLE leaves the session counters at zero.
        if (w_state == ST_IDLE) begin
            w_amount = '0;
            w_paid   = '0;
            w_remain = '0;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_amount   <= '0;
            r_paid     <= '0;
            r_remain   <= '0;
            r_charging <= 1'b0;
            r_err      <= 1'b0;
            r_refund   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_amount   <= w_amount;
            r_paid     <= w_paid;
            r_remain   <= w_remain;
            r_charging <= (w_state == ST_CHARGE);
            r_err      <= w_err;
            r_refund   <= w_refund;
            r_done     <= (w_state == ST_DONE);
        end
    end

    assign state       = r_state;
    assign amount      = r_amount;
    assign paid        = r_paid;
    assign remain_time = r_remain;
    assign charging    = r_charging;
    assign err         = r_err;
    assign refund      = r_refund;
    assign done        = r_done;

endmodule
`default_nettype wire
